// File: rtl/l1_pkg.sv
// Shared types and constants for the L1 eviction reader.
// Holds the FSM state encoding, the skid FIFO depth and the per-byte parity helper.
package l1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } evict_state_t;

    localparam int FIFO_DEPTH         = 3;
    localparam int DEFAULT_BEATS_LOG2 = 2;

    // Even parity per byte: each bit makes its byte plus the bit an even count of ones.
    function automatic logic [3:0] byte_even_parity(input logic [31:0] word);
        byte_even_parity = {^word[31:24], ^word[23:16], ^word[15:8], ^word[7:0]};
    endfunction

endpackage

// File: rtl/evict_skid_fifo.sv
// Three-entry shift FIFO between the datastore read port and the outbound beat port.
// The head always sits in entry 0, so the outbound beat is driven straight from a flop.
module evict_skid_fifo
    import l1_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem     [FIFO_DEPTH];
    logic [WIDTH-1:0] w_mem_nxt [FIFO_DEPTH];
    logic [1:0]       r_count;
    logic [1:0]       w_count_nxt;
    logic [1:0]       w_wr_idx;
    logic             w_pop;
    logic             w_push;

    // Next-state: shift down on pop, then write the new entry just above the survivors.
    always_comb begin
        w_pop       = i_pop && (r_count != 2'd0);
        w_push      = i_push && ((r_count != 2'(FIFO_DEPTH)) || w_pop);
        w_wr_idx    = r_count - {1'b0, w_pop};
        w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
            w_mem_nxt[i] = w_pop ? r_mem[i+1] : r_mem[i];
        end
        w_mem_nxt[FIFO_DEPTH-1] = w_pop ? {WIDTH{1'b0}} : r_mem[FIFO_DEPTH-1];
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_mem_nxt[i] = (w_push && (w_wr_idx == 2'(i))) ? i_push_data : w_mem_nxt[i];
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_count <= 2'd0;
        end else begin
            r_mem   <= w_mem_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign o_head  = r_mem[0];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/l1_evict_reader.sv
// Reads one cache line out of the L1 datastore and streams it as 32-bit beats.
// Optional feature macro: L1_EVICT_PARITY_EN adds mem_wpar (per-byte even parity).
module l1_evict_reader
    import l1_pkg::*;
#(
    parameter int addr_width = 10,
    parameter int beats_log2 = DEFAULT_BEATS_LOG2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             evict_valid,
    input  logic [addr_width-beats_log2-1:0] evict_line,
    output logic                             evict_ready,
    output logic [addr_width-1:0]            ds_addr,
    input  logic [31:0]                      ds_q,
    output logic                             mem_wvalid,
    output logic [31:0]                      mem_wdata,
    output logic                             mem_wlast,
`ifdef L1_EVICT_PARITY_EN
    output logic [3:0]                       mem_wpar,
`endif
    input  logic                             mem_wready,
    output logic                             busy
);

    localparam int LINE_W = addr_width - beats_log2;
`ifdef L1_EVICT_PARITY_EN
    localparam int DATA_W = 36;
`else
    localparam int DATA_W = 32;
`endif
    localparam logic [beats_log2-1:0] LAST_BEAT = '1;

    evict_state_t            r_state;
    logic [LINE_W-1:0]       r_line;
    logic [beats_log2-1:0]   r_beat;
    logic [beats_log2-1:0]   r_pop_beat;
    logic                    r_rd_pend;

    logic [DATA_W-1:0]       w_push_data;
    logic [DATA_W-1:0]       w_fifo_head;
    logic                    w_fifo_valid;
    logic [1:0]              w_fifo_count;
    logic                    w_accept;
    logic                    w_issue;
    logic                    w_pop;
    logic                    w_last_pop;

    // A read may only issue when the FIFO can absorb it and everything already in flight.
    always_comb begin
        w_accept   = evict_valid && (r_state == ST_IDLE);
        w_issue    = (r_state == ST_READ) &&
                     (({1'b0, w_fifo_count} + {2'b00, r_rd_pend}) < 3'(FIFO_DEPTH));
        w_pop      = w_fifo_valid && mem_wready;
        w_last_pop = w_pop && (r_pop_beat == LAST_BEAT);
`ifdef L1_EVICT_PARITY_EN
        w_push_data = {byte_even_parity(ds_q), ds_q};
`else
        w_push_data = ds_q;
`endif
    end

    // Line FSM, address beat counter, read-in-flight flag and outbound beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_line     <= {LINE_W{1'b0}};
            r_beat     <= {beats_log2{1'b0}};
            r_pop_beat <= {beats_log2{1'b0}};
            r_rd_pend  <= 1'b0;
        end else begin
            r_rd_pend <= w_issue;
            if (w_pop) begin
                r_pop_beat <= r_pop_beat + beats_log2'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_line  <= evict_line;
                        r_beat  <= {beats_log2{1'b0}};
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_issue) begin
                        r_beat <= r_beat + beats_log2'(1);
                        if (r_beat == LAST_BEAT) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    evict_skid_fifo #(
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_rd_pend),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_valid     (w_fifo_valid),
        .o_count     (w_fifo_count)
    );

    assign evict_ready = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign ds_addr     = {r_line, r_beat};
    assign mem_wvalid  = w_fifo_valid;
    assign mem_wdata   = w_fifo_head[31:0];
    assign mem_wlast   = w_fifo_valid && (r_pop_beat == LAST_BEAT);
`ifdef L1_EVICT_PARITY_EN
    assign mem_wpar    = w_fifo_head[35:32];
`endif

endmodule

// File: tb/tb_l1_evict_reader.sv
// Scoreboard bench for l1_evict_reader: stimulus queues expected beats, a monitor compares them.
// Parity checks are compiled in when L1_EVICT_PARITY_EN is defined.
module tb_l1_evict_reader;

    localparam int AW = 10;
    localparam int BL = 2;
    localparam int LW = AW - BL;

    logic          clk = 1'b0;
    logic          rst;
    logic          evict_valid;
    logic [LW-1:0] evict_line;
    logic          evict_ready;
    logic [AW-1:0] ds_addr;
    logic [31:0]   ds_q;
    logic          mem_wvalid;
    logic [31:0]   mem_wdata;
    logic          mem_wlast;
`ifdef L1_EVICT_PARITY_EN
    logic [3:0]    mem_wpar;
`endif
    logic          mem_wready;
    logic          busy;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   rdy_mode = 0;   // 0: ready high, 1: random, 2: driven by the test itself

    l1_evict_reader #(
        .addr_width (AW),
        .beats_log2 (BL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .evict_valid (evict_valid),
        .evict_line  (evict_line),
        .evict_ready (evict_ready),
        .ds_addr     (ds_addr),
        .ds_q        (ds_q),
        .mem_wvalid  (mem_wvalid),
        .mem_wdata   (mem_wdata),
        .mem_wlast   (mem_wlast),
`ifdef L1_EVICT_PARITY_EN
        .mem_wpar    (mem_wpar),
`endif
        .mem_wready  (mem_wready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        if (a == 10'h3FC) return 32'h0103_FF00;
        else return 32'hC0DE_0000 + {22'd0, a};
    endfunction

    function automatic logic [3:0] tb_par(input logic [31:0] w);
        logic [3:0] p;
        for (int b = 0; b < 4; b++) begin
            p[b] = 1'b0;
            for (int k = 0; k < 8; k++) p[b] = p[b] ^ w[8*b+k];
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic push_line(input logic [LW-1:0] line);
        exp_t e;
        for (int b = 0; b < 4; b++) begin
            e.data = mem_word(AW'(int'(line) * 4 + b));
            e.last = (b == 3);
            sb_q.push_back(e);
        end
    endtask

    task automatic send_line(input logic [LW-1:0] line);
        int t = 0;
        @(negedge clk);
        while (!evict_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!evict_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: evict_ready got 0, required 1");
        end else begin
            evict_valid = 1'b1;
            evict_line  = line;
            push_line(line);
            @(posedge clk);
            #1;
            evict_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((busy || mem_wvalid) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_reached", {31'd0, busy || mem_wvalid}, 32'd0);
        chk("sb_drained", sb_q.size(), 32'd0);
    endtask

    // Datastore model: one-cycle read latency.
    initial begin
        ds_q = 32'd0;
        forever begin
            @(posedge clk);
            ds_q <= mem_word(ds_addr);
        end
    end

    // Sink ready driver for the non-directed modes.
    initial begin
        mem_wready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) mem_wready = 1'($urandom_range(0, 1));
            else if (rdy_mode == 0) mem_wready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each accepted beat and checks stall stability.
    initial begin
        exp_t        e;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data  = 32'd0;
        logic        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", {31'd0, mem_wvalid}, 32'd1);
                    chk("stall_data", mem_wdata, prev_data);
                    chk("stall_last", {31'd0, mem_wlast}, {31'd0, prev_last});
                end
                if (!mem_wvalid) chk("wlast_without_valid", {31'd0, mem_wlast}, 32'd0);
                if (mem_wvalid && mem_wready) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got data %0h, required no beat", mem_wdata);
                    end else begin
                        e = sb_q.pop_front();
                        chk("beat_data", mem_wdata, e.data);
                        chk("beat_last", {31'd0, mem_wlast}, {31'd0, e.last});
`ifdef L1_EVICT_PARITY_EN
                        chk("beat_par", {28'd0, mem_wpar}, {28'd0, tb_par(e.data)});
`endif
                    end
                end
                prev_stall = mem_wvalid && !mem_wready;
                prev_data  = mem_wdata;
                prev_last  = mem_wlast;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        int   k;
        rst         = 1'b1;
        evict_valid = 1'b0;
        evict_line  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_evict_ready", {31'd0, evict_ready}, 32'd1);
        chk("rst_mem_wvalid", {31'd0, mem_wvalid}, 32'd0);
        chk("rst_mem_wlast", {31'd0, mem_wlast}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ds_addr", {22'd0, ds_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic latency: line 0x05 with the sink always ready.
        @(negedge clk);
        chk("c0_ready", {31'd0, evict_ready}, 32'd1);
        evict_valid = 1'b1;
        evict_line  = 8'h05;
        push_line(8'h05);
        @(posedge clk);
        #1;
        evict_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c <= 4) chk("lat_ds_addr", {22'd0, ds_addr}, 32'h14 + c - 1);
            chk("lat_wvalid", {31'd0, mem_wvalid}, (c >= 3 && c <= 6) ? 32'd1 : 32'd0);
            chk("lat_wlast", {31'd0, mem_wlast}, (c == 6) ? 32'd1 : 32'd0);
            chk("lat_ready", {31'd0, evict_ready}, (c == 7) ? 32'd1 : 32'd0);
        end

        // Backpressure: sink stalls in cycles 2..9.
        rdy_mode = 2;
        @(negedge clk);
        evict_valid = 1'b1;
        evict_line  = 8'h0A;
        push_line(8'h0A);
        @(posedge clk);
        #1;
        evict_valid = 1'b0;
        mem_wready  = 1'b1;
        for (int c = 2; c <= 12; c++) begin
            @(posedge clk);
            #1;
            mem_wready = (c <= 9) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (c == 5 || c == 9) chk("stall_ds_addr", {22'd0, ds_addr}, 32'h2B);
            if (c >= 3 && c <= 9) chk("stall_wvalid", {31'd0, mem_wvalid}, 32'd1);
        end
        rdy_mode = 0;
        wait_idle();

        // evict_valid held through a transfer with the line index changing.
        @(negedge clk);
        evict_valid = 1'b1;
        evict_line  = 8'h30;
        push_line(8'h30);
        @(posedge clk);
        #1;
        found = 1'b0;
        k     = 0;
        while (!found && k < 20) begin
            evict_line = 8'h40 + 8'(k);
            @(negedge clk);
            k++;
            if (evict_ready) begin
                found = 1'b1;
                chk("hold_first_drained", sb_q.size(), 32'd0);
                chk("hold_accept_cycle", k, 32'd7);
                push_line(evict_line);
                @(posedge clk);
                #1;
                evict_valid = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        evict_valid = 1'b0;
        chk("hold_second_accepted", {31'd0, found}, 32'd1);
        wait_idle();

        // Reset during cycle 4 of a transfer.
        @(negedge clk);
        evict_valid = 1'b1;
        evict_line  = 8'h21;
        push_line(8'h21);
        @(posedge clk);
        #1;
        evict_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_wvalid", {31'd0, mem_wvalid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, evict_ready}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("mid_rst_no_stale", {31'd0, mem_wvalid}, 32'd0);
        end
        send_line(8'h22);
        wait_idle();

`ifdef L1_EVICT_PARITY_EN
        send_line(8'hFF);
        wait_idle();
`endif

        // Random backpressure over 100 lines.
        rdy_mode = 1;
        for (int i = 0; i < 100; i++) begin
            send_line(LW'(i * 37 + 11));
        end
        wait_idle();
        rdy_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/l1_evict_reader.md
L1_EVICT_READER -- requirements
Module: l1_evict_reader

Interface
- REQ-001 SHALL have parameter addr_width, default 10: word address width of the L1 datastore port it reads.
- REQ-002 SHALL have parameter beats_log2, default 2: log2 of 32-bit words per cache line; addr_width > beats_log2.
- REQ-003 clk  input  1  sole clock; all logic on its rising edge.
- REQ-004 rst  input  1  reset, synchronous and active-high.
- REQ-005 evict_valid  input  1  eviction request.
- REQ-006 evict_line  input  addr_width-beats_log2  index of the line to read out.
- REQ-007 evict_ready  output  1  request accepted when high together with evict_valid.
- REQ-008 ds_addr  output  addr_width  datastore read word address.
- REQ-009 ds_q  input  32  datastore read data, valid one cycle after ds_addr.
- REQ-010 mem_wvalid  output  1  outbound beat valid.
- REQ-011 mem_wdata  output  32  outbound beat data.
- REQ-012 mem_wlast  output  1  final beat of line.
- REQ-013 mem_wready  input  1  sink accepts beat.
- REQ-014 busy  output  1  high in any state other than IDLE.

Function
- REQ-015 States SHALL be IDLE, READ and DRAIN; evict_ready = 1 only in IDLE.
- REQ-016 An accept (evict_valid and evict_ready both high) SHALL latch evict_line and move IDLE -> READ.
- REQ-017 In READ, ds_addr SHALL equal {line, beat}, with beat counting 0 .. 2^beats_log2-1.
- REQ-018 A read issues in a cycle only if FIFO entries plus reads in flight (issued in the previous cycle) < 3.
- REQ-019 ds_q for each issued read SHALL be pushed into a 3-entry FIFO at the end of the following cycle.
- REQ-020 After the last beat address issues, the state SHALL move READ -> DRAIN and the beat counter SHALL wrap to 0.
- REQ-021 mem_wvalid SHALL equal FIFO not empty; mem_wdata SHALL be the FIFO head.
- REQ-022 A pop occurs on mem_wvalid and mem_wready.
- REQ-023 mem_wvalid, mem_wdata and mem_wlast SHALL hold stable while mem_wready is low.
- REQ-024 mem_wlast SHALL be high only with the head entry for beat 2^beats_log2-1.
- REQ-025 Pop of the last beat SHALL move DRAIN -> IDLE; evict_ready rises the next cycle, and no accept occurs in the same cycle as the last pop.
- REQ-026 Latency, with cycle 0 = accept: ds_addr = beat 0 in cycle 1; beat 0 appears on mem_wvalid in cycle 3.
- REQ-027 With mem_wready held high, beats SHALL leave one per cycle, in cycles 3 .. 2+2^beats_log2.
- REQ-028 Backpressure of any length SHALL cause no beat loss, duplication or reordering.
- REQ-029 evict_valid SHALL be ignored while busy.

Reset
- REQ-030 Reset values: evict_ready=1, mem_wvalid=0, mem_wlast=0, mem_wdata=0, ds_addr=0, busy=0; state IDLE, FIFO empty, counters 0.
- REQ-031 Reset asserted mid-line SHALL abandon the transfer; mem_wvalid SHALL be 0 in the cycle after rst is sampled high, and no stale beats SHALL follow.

Configuration
- REQ-032 With L1_EVICT_PARITY_EN defined, output mem_wpar[3:0] SHALL exist and carry even parity of each byte of mem_wdata, travelling with the beat in the FIFO.
- REQ-033 Without L1_EVICT_PARITY_EN, mem_wpar SHALL be absent and behaviour otherwise identical.

Structure
- REQ-034 Package l1_pkg SHALL hold the state enum, the FIFO depth constant (3) and the default beats_log2.
- REQ-035 The FIFO SHALL be sub-module evict_skid_fifo, parameterised by width (32, or 36 with parity).

Verification
- REQ-036 addr_width=10, beats_log2=2, accept line 0x05, mem_wready=1 -> ds_addr 0x014..0x017 in cycles 1-4; beats 3-6 = mem words 0x14..0x17; wlast in cycle 6; evict_ready high in cycle 7.
- REQ-037 mem_wready=0 cycles 2-9, then 1 -> at most 3 reads issue before the stall; all 4 beats delivered in order; data stable while stalled.
- REQ-038 Random mem_wready at 50% over 100 lines -> scoreboard shows zero mismatches and exactly one wlast per line.
- REQ-039 evict_valid held high during a transfer with evict_line changing -> second line accepted only after IDLE, with the originally latched line data.
- REQ-040 rst pulsed in cycle 4 of a transfer -> mem_wvalid 0 from cycle 5; next accept produces a clean 4-beat line.
- REQ-041 L1_EVICT_PARITY_EN defined, word 0x0103_FF00 -> mem_wpar = 4'b1000 (byte3..byte0).
